// File: rtl/pyramid_mem_arbiter_if.sv
// Read-port bundle between the pyramid engines, the arbiter and the frame/flow buffer.
// The master side is the requester/memory environment; the slave side is the arbiter.
interface pyramid_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 16
);
    logic                        pri_en;
    logic [2:0]                  pri_id;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        mem_rd_en;
    logic [ADDR_W-1:0]           mem_rd_addr;
    logic [DATA_W-1:0]           mem_rd_data;
    logic                        busy;

    modport master (
        output pri_en, pri_id, req, req_addr, mem_rd_data,
        input  gnt, rvalid, rdata, mem_rd_en, mem_rd_addr, busy
    );

    modport slave (
        input  pri_en, pri_id, req, req_addr, mem_rd_data,
        output gnt, rvalid, rdata, mem_rd_en, mem_rd_addr, busy
    );
endinterface

// File: rtl/pyramid_mem_arbiter.sv
// Single-port read arbiter for the pyramid engines: stage-owner priority over round-robin,
// one grant per cycle, returns routed back through a fixed-latency ID pipeline.
module pyramid_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 5,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pyramid_mem_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
    logic                              mem_rd_en_q;
    logic [ADDR_W-1:0]                 mem_rd_addr_q;
    logic [RD_LATENCY:0]               pipe_vld_q;
    logic [RD_LATENCY:0][IDX_W-1:0]    pipe_id_q;
    logic [NUM_REQ-1:0]                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]                 rdata_q;

    logic                              pri_hit;
    logic                              gnt_any;
    logic                              rr_grant;
    logic [IDX_W-1:0]                  gnt_idx;
    logic [IDX_W-1:0]                  cand_idx;
    logic [NUM_REQ-1:0]                gnt_vec;
    logic [ADDR_W-1:0]                 sel_addr;

    // Out-of-range pri_id is not an error; it just falls through to round-robin.
    always_comb begin
        pri_hit = 1'b0;
        if (bus.pri_en && (32'(bus.pri_id) < NUM_REQ)) begin
            pri_hit = bus.req[bus.pri_id];
        end
    end

    always_comb begin
        gnt_any  = 1'b0;
        rr_grant = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        if (!rst) begin
            if (pri_hit) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(bus.pri_id);
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand_idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
                    if (!gnt_any && bus.req[cand_idx]) begin
                        gnt_any  = 1'b1;
                        rr_grant = 1'b1;
                        gnt_idx  = cand_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_grant) begin
            rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign sel_addr = bus.req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];

    always_comb begin
        rvalid_d = '0;
        if (pipe_vld_q[RD_LATENCY]) begin
            rvalid_d[pipe_id_q[RD_LATENCY]] = 1'b1;
        end
    end

    // Reset flushes the ID pipeline, so reads in flight never produce an rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            pipe_vld_q    <= '0;
            pipe_id_q     <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_rd_en_q <= gnt_any;
            if (gnt_any) begin
                mem_rd_addr_q <= sel_addr;
            end
            pipe_vld_q <= {pipe_vld_q[RD_LATENCY-1:0], gnt_any};
            pipe_id_q  <= {pipe_id_q[RD_LATENCY-1:0], gnt_idx};
            rvalid_q   <= rvalid_d;
            if (pipe_vld_q[RD_LATENCY]) begin
                rdata_q <= bus.mem_rd_data;
            end
        end
    end

    assign bus.gnt         = gnt_vec;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_rd_addr = mem_rd_addr_q;
    assign bus.busy        = (|pipe_vld_q) | mem_rd_en_q;

endmodule

// File: tb/tb_pyramid_mem_arbiter.sv
// Bench for pyramid_mem_arbiter: directed grant checks plus a scoreboard of expected
// returns (requester, data, cycle) pushed at grant time and popped on rvalid.
module tb_pyramid_mem_arbiter;
    localparam int unsigned NUM_REQ = 5;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RL      = 2;

    typedef struct {
        int               idx;
        logic [DATA_W-1:0] data;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    logic [ADDR_W-1:0] addr_tbl [NUM_REQ];
    logic [ADDR_W-1:0] mem_a0, mem_a1;

    pyramid_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pyramid_mem_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        if (a == 17'h00100) return 16'hBEEF;
        return (a[15:0] * 16'd7) ^ 16'h3C3C ^ {15'b0, a[16]};
    endfunction

    // Memory model: data for the address read at cycle M is valid during M+RL.
    always @(posedge clk) begin
        mem_a0 <= bus.mem_rd_addr;
        mem_a1 <= mem_a0;
    end
    assign bus.mem_rd_data = mem_fn(mem_a1);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rvalid != '0) begin
            if (sb_q.size() == 0) begin
                check_eq("rvalid_spurious", 32'(bus.rvalid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rvalid", 32'(bus.rvalid), 32'(1) << e.idx);
                check_eq("rdata", 32'(bus.rdata), 32'(e.data));
                check_eq("rlatency", cyc, e.cyc);
            end
        end
    end

    task automatic load_addrs();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_addr[i*ADDR_W +: ADDR_W] = addr_tbl[i];
        end
    endtask

    // Drives one cycle of request inputs and checks the combinational grant.
    task automatic cycle_step(input logic [NUM_REQ-1:0] r, input logic pe, input logic [2:0] pid,
                              input int exp_idx, input bit track);
        logic [NUM_REQ-1:0] exp_g;
        bus.req    = r;
        bus.pri_en = pe;
        bus.pri_id = pid;
        @(negedge clk);
        exp_g = (exp_idx >= 0) ? NUM_REQ'(1 << exp_idx) : '0;
        check_eq("gnt", 32'(bus.gnt), 32'(exp_g));
        if (track && exp_idx >= 0) begin
            sb_q.push_back('{exp_idx, mem_fn(addr_tbl[exp_idx]), cyc + 2 + int'(RL)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_step('0, 1'b0, 3'd0, -1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        addr_tbl[0] = 17'h00010;
        addr_tbl[1] = 17'h00100;
        addr_tbl[2] = 17'h01234;
        addr_tbl[3] = 17'h0ABCD;
        addr_tbl[4] = 17'h1FFFF;
        rst        = 1'b1;
        bus.req    = '1;
        bus.pri_en = 1'b0;
        bus.pri_id = 3'd0;
        load_addrs();

        #2;
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
        check_eq("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_eq("rst_mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request with a 4-cycle return.
        cycle_step(5'b00010, 1'b0, 3'd0, 1, 1'b1);
        check_eq("single_mem_rd_en", 32'(bus.mem_rd_en), 32'd1);
        check_eq("single_mem_rd_addr", 32'(bus.mem_rd_addr), 32'h00100);
        check_eq("single_busy", 32'(bus.busy), 32'd1);
        idle(6);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        // Round-robin from reset.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle_step(5'b11111, 1'b0, 3'd0, k % 5, 1'b1);
        end
        idle(6);

        // Stage-owner priority, then round-robin resumes at rr_ptr=0.
        do_reset();
        for (int k = 0; k < 10; k++) cycle_step(5'b11111, 1'b1, 3'd3, 3, 1'b1);
        cycle_step(5'b10111, 1'b1, 3'd3, 0, 1'b1);
        cycle_step(5'b10111, 1'b1, 3'd3, 1, 1'b1);
        cycle_step(5'b10111, 1'b1, 3'd3, 2, 1'b1);
        cycle_step(5'b10111, 1'b1, 3'd3, 4, 1'b1);

        // Out-of-range pri_id falls back to round-robin.
        cycle_step(5'b00110, 1'b1, 3'd7, 1, 1'b1);
        cycle_step(5'b00110, 1'b1, 3'd7, 2, 1'b1);
        idle(6);

        // Back-to-back mixed requesters.
        cycle_step(5'b00100, 1'b0, 3'd0, 2, 1'b1);
        cycle_step(5'b00001, 1'b0, 3'd0, 0, 1'b1);
        cycle_step(5'b10000, 1'b0, 3'd0, 4, 1'b1);
        idle(6);

        // Reset mid-flight: these three reads must never return.
        cycle_step(5'b11111, 1'b0, 3'd0, 0, 1'b0);
        cycle_step(5'b11111, 1'b0, 3'd0, 1, 1'b0);
        cycle_step(5'b11111, 1'b0, 3'd0, 2, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check_eq("midrst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("midrst_rdata", 32'(bus.rdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle_step(5'b11111, 1'b0, 3'd0, 0, 1'b1);
        idle(8);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pyramid_mem_arbiter.md
# pyramid_mem_arbiter

Single-port read arbiter that shares the frame/flow buffer read port between the pyramid pipeline engines: pyramid builder, L-K solver, upsampler, warp and accumulator. Requests are granted one per cycle. The requester that owns the current pipeline stage gets strict priority; all others are served round-robin. Return data is routed back to the originating requester through a fixed-latency ID pipeline.

## Interface
- NUM_REQ, 5, number of requesters (index 0=build, 1=solve, 2=upsample, 3=warp, 4=accum)
- ADDR_W, 17, read address width (covers 320x240 = 76800 words)
- DATA_W, 16, read data width
- RD_LATENCY, 2, memory cycles from mem_rd_en to valid mem_rd_data (>=1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pri_en  in  1  enable stage-owner priority
- pri_id  in  3  index of stage-owner requester, decoded by the top from the control FSM state
- req  in  NUM_REQ  per-requester read request, held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- rvalid  out  NUM_REQ  one-hot return strobe
- rdata  out  DATA_W  return data, broadcast, qualified by rvalid
- mem_rd_en  out  1  registered memory read enable
- mem_rd_addr  out  ADDR_W  registered memory read address
- mem_rd_data  in  DATA_W  memory read data
- busy  out  1  reads in flight

## Operation
- Arbitration runs every cycle and grants at most one requester.
- Priority override: if pri_en=1, pri_id<NUM_REQ and req[pri_id]=1, then gnt[pri_id]=1.
- Otherwise, round-robin: grant the first asserted req at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
- rr_ptr is (granted index + 1) mod NUM_REQ after any round-robin grant. A priority grant leaves rr_ptr unchanged.
- pri_en=1 with pri_id>=NUM_REQ falls back to round-robin. This is not an error.
- On any grant:
  - mem_rd_en<=1 next cycle.
  - mem_rd_addr<=addr of the granted requester.
  - The granted ID plus a valid bit enter a RD_LATENCY+1 deep shift register.
- At the end of the shift register, rdata<=mem_rd_data and rvalid<=onehot(ID) are both registered.
- No grant in a cycle: mem_rd_en<=0 and mem_rd_addr holds its value. A bubble enters the ID pipeline.
- Requesters must tolerate no grant. A request may stay pending indefinitely only while a higher-priority requester has req asserted every cycle.
- No backpressure on returns: a requester must accept rvalid on any cycle.
- busy=1 while any ID-pipeline valid bit is set or mem_rd_en=1.
- Reset values:
  - gnt: 0 whenever rst=1 (gnt is forced low during reset).
  - rvalid=0, rdata=0, mem_rd_en=0, mem_rd_addr=0, busy=0.
  - rr_ptr=0, ID pipeline cleared.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is produced for them.
- Simultaneous events:
  - The priority requester and the rr_ptr requester both asserted: the priority requester wins and rr_ptr holds.
  - A requester dropping req in the same cycle it would be granted receives no gnt, because gnt is combinational from the current req.

## Timing
- Cycle N: req[i]=1 and gnt[i]=1.
- Cycle N+1: mem_rd_en=1 with mem_rd_addr=req_addr[i] as sampled at N.
- Cycle N+1+RD_LATENCY: mem_rd_data is valid.
- Cycle N+2+RD_LATENCY: rvalid[i]=1 with rdata. Total latency is 4 cycles at the default RD_LATENCY.
- Throughput is one read per cycle sustained.
- Returns come back in grant order.
- rvalid is never asserted in a cycle without a matching earlier grant.
- pri_en and pri_id are sampled combinationally each cycle. They may change on any cycle, and the change takes effect in the same cycle.

## Test plan
- Single request: req[1]=1 with addr 0x00100 for one cycle.
  - gnt[1]=1 at N.
  - mem_rd_en=1 with addr 0x00100 at N+1.
  - Memory model returns 0xBEEF; rvalid[1]=1 with rdata=0xBEEF at N+4.
- Round-robin: req=5'b11111 held, pri_en=0, from reset.
  - Grant order 0,1,2,3,4,0.
  - Exactly one gnt bit set per cycle.
- Priority: pri_en=1, pri_id=3, req=5'b11111 held for 10 cycles.
  - gnt[3]=1 every cycle.
  - Then drop req[3]: round-robin resumes from rr_ptr=0, granting 0,1,2,4.
- Invalid priority: pri_en=1, pri_id=7, req=5'b00110.
  - Round-robin grants 1, then 2.
- Back-to-back mixed: grants to 2,0,4 on consecutive cycles with distinct addresses.
  - rvalid[2], rvalid[0], rvalid[4] on consecutive cycles.
  - Each carries the data for its own address.
- Reset mid-flight: assert rst for 1 cycle, 2 cycles after three back-to-back grants.
  - No rvalid ever asserted for those reads.
  - busy=0, mem_rd_en=0 immediately.
  - The next grant after reset uses rr_ptr=0.
